reaction_timer: RTL and testbench

Datapath-plus-control partner to the lab-2 reaction-game controller. It generates the random 1–2999 ms pre-delay from a free-running LFSR and counts that delay down in milliseconds. It then lights the LED (`led`), measures the player's reaction in milliseconds until the next `ss` press, and holds the result for display. It sits between the debounced `ss` button pulse and the 7-segment result driver.

---
 rtl/reaction_pkg.sv | 44 ++++
 rtl/lfsr12.sv | 23 ++
 rtl/reaction_timer.sv | 114 +++++++++++
 tb/tb_reaction_timer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/reaction_pkg.sv
// Shared types, constants and LFSR helpers for the reaction timer.
package reaction_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    REACT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int          DELAY_LIMIT = 3000;
  localparam int          RESULT_MAX  = 9999;
  localparam logic [11:0] LFSR_SEED   = 12'hACE;

  // Feedback taps for x^12 + x^6 + x^4 + x + 1 (the x^12 term is the shifted-out MSB).
  localparam logic [11:0] LFSR_TAPS   = 12'h053;

  // One step of the left-shifting Galois LFSR.
  function automatic logic [11:0] lfsr_next(input logic [11:0] cur);
    logic [11:0] nxt;
    nxt = {cur[10:0], 1'b0};
    if (cur[11]) begin
      nxt = nxt ^ LFSR_TAPS;
    end
    return nxt;
  endfunction

  // Fold the 1..4095 LFSR range into the pre-delay range. A raw value of
  // exactly 3000 would fold to 0, which would leave WAIT with nothing to
  // count down, so it is lifted to the 1 ms minimum.
  function automatic logic [11:0] delay_from_lfsr(input logic [11:0] raw);
    logic [11:0] d;
    if (raw < 12'(DELAY_LIMIT)) begin
      d = raw;
    end else begin
      d = raw - 12'(DELAY_LIMIT);
    end
    if (d == 12'd0) begin
      d = 12'd1;
    end
    return d;
  endfunction

endpackage

// File: rtl/lfsr12.sv
// Free-running 12-bit Galois LFSR used as the pre-delay random source.
module lfsr12
  import reaction_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  output logic [11:0] q
);

  logic [11:0] lfsr_q;

  // Advance every clock; the nonzero seed keeps the sequence off the all-zero lockup state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_next(lfsr_q);
    end
  end

  assign q = lfsr_q;

endmodule

// File: rtl/reaction_timer.sv
// Reaction-game datapath: random pre-delay, LED window, reaction-time
// measurement in milliseconds, and a held result for the display driver.
module reaction_timer
  import reaction_pkg::*;
#(
  parameter int CLK_PER_MS = 50000,
  parameter int RESULT_W   = 14
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ss,
  output logic                led,
  output logic [RESULT_W-1:0] result,
  output logic                result_valid,
  output logic                early,
  output logic                busy
);

  localparam int PW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;

  state_t              state_q;
  logic [PW-1:0]       presc_q;
  logic [PW-1:0]       presc_d;
  logic [11:0]         delay_q;
  logic [11:0]         delay_d;
  logic [RESULT_W-1:0] rt_q;
  logic [RESULT_W-1:0] rt_d;
  logic [RESULT_W-1:0] result_q;
  logic                early_q;
  logic [11:0]         lfsr_w;
  logic                tick;

  lfsr12 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .q     (lfsr_w)
  );

  // Millisecond tick, prescaler successor, folded pre-delay and the reaction
  // count including a tick on this cycle (held at the ceiling, never wraps).
  always_comb begin
    tick    = (presc_q == PW'(CLK_PER_MS - 1));
    presc_d = tick ? '0 : presc_q + PW'(1);
    delay_d = delay_from_lfsr(lfsr_w);
    rt_d    = rt_q;
    if (tick && (rt_q != RESULT_W'(RESULT_MAX))) begin
      rt_d = rt_q + RESULT_W'(1);
    end
  end

  // Control FSM together with the prescaler, delay down-counter and reaction counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      presc_q  <= '0;
      delay_q  <= '0;
      rt_q     <= '0;
      result_q <= '0;
      early_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ss) begin
            state_q <= WAIT;
            delay_q <= delay_d;
            presc_q <= '0;
          end
        end
        WAIT: begin
          // A press on the expiry cycle still counts as a false start.
          if (ss) begin
            state_q  <= DONE;
            early_q  <= 1'b1;
            result_q <= '0;
          end else begin
            presc_q <= presc_d;
            if (tick) begin
              if (delay_q == 12'd1) begin
                state_q <= REACT;
                rt_q    <= '0;
                presc_q <= '0;
              end else begin
                delay_q <= delay_q - 12'd1;
              end
            end
          end
        end
        REACT: begin
          presc_q <= presc_d;
          rt_q    <= rt_d;
          // Timeout and a press on the saturating tick both report the ceiling.
          if (ss || (rt_d == RESULT_W'(RESULT_MAX))) begin
            state_q  <= DONE;
            result_q <= rt_d;
            early_q  <= 1'b0;
          end
        end
        DONE: begin
          if (ss) begin
            state_q <= IDLE;
            early_q <= 1'b0;
          end
        end
      endcase
    end
  end

  assign led          = (state_q == REACT);
  assign busy         = (state_q == WAIT) || (state_q == REACT);
  assign result_valid = (state_q == DONE);
  assign early        = early_q;
  assign result       = result_q;

endmodule

// File: tb/tb_reaction_timer.sv
// Directed bench for reaction_timer with CLK_PER_MS = 4.
module tb_reaction_timer;

  localparam int CPM = 4;
  localparam int RW  = 14;

  logic          clk;
  logic          reset;
  logic          ss;
  logic          led;
  logic [RW-1:0] result;
  logic          result_valid;
  logic          early;
  logic          busy;

  int n_tests = 0;
  int n_fail  = 0;

  reaction_timer #(.CLK_PER_MS(CPM), .RESULT_W(RW)) dut (
    .clk          (clk),
    .reset        (reset),
    .ss           (ss),
    .led          (led),
    .result       (result),
    .result_valid (result_valid),
    .early        (early),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference LFSR: x^12 + x^6 + x^4 + x + 1, Galois form, shifting toward the MSB.
  function automatic logic [11:0] m_step(input logic [11:0] s);
    logic [11:0] n;
    n     = s << 1;
    n[0]  = s[11];
    n[1]  = s[0] ^ s[11];
    n[4]  = s[3] ^ s[11];
    n[6]  = s[5] ^ s[11];
    return n;
  endfunction

  function automatic int m_delay(input logic [11:0] v);
    int d;
    d = (int'(v) < 3000) ? int'(v) : int'(v) - 3000;
    if (d == 0) d = 1;
    return d;
  endfunction

  logic [11:0] m_lfsr;
  always @(posedge clk or posedge reset) begin
    if (reset) m_lfsr <= 12'hACE;
    else       m_lfsr <= m_step(m_lfsr);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Step until the modelled next delay lies in [lo, hi]; returns cycles waited.
  task automatic wait_small(input int lo, input int hi, output int g);
    g = 0;
    while (!((m_delay(m_lfsr) >= lo) && (m_delay(m_lfsr) <= hi)) && (g < 5000)) begin
      step(1);
      g++;
    end
    chk("wait_small_bound", (g < 5000), 1);
  endtask

  task automatic wait_led(output int n);
    n = 0;
    while (!led && (n < 15000)) begin
      step(1);
      n++;
    end
  endtask

  task automatic press();
    ss = 1'b1;
    step(1);
    ss = 1'b0;
  endtask

  int  g0, g, d1, d, n;
  logic led_seen;
  logic seen_hi;

  initial begin
    ss    = 1'b0;
    reset = 1'b1;
    step(3);
    chk("rst_led", led, 0);
    chk("rst_busy", busy, 0);
    chk("rst_valid", result_valid, 0);
    chk("rst_early", early, 0);
    chk("rst_result", result, 0);
    chk("rst_lfsr", dut.u_lfsr.q, 12'hACE);
    reset = 1'b0;

    // Normal run: 250 ms reaction
    wait_small(1, 150, g0);
    d1 = m_delay(m_lfsr);
    press();
    chk("norm_busy", busy, 1);
    chk("norm_led_wait", led, 0);
    chk("norm_delay", dut.delay_q, d1);
    wait_led(n);
    chk("norm_led_rise_cycles", n, 4 * d1);
    step(999);
    chk("norm_led_before", led, 1);
    press();
    chk("norm_result", result, 250);
    chk("norm_valid", result_valid, 1);
    chk("norm_early", early, 0);
    chk("norm_led", led, 0);
    chk("norm_busy_done", busy, 0);
    step(5);
    chk("norm_hold", result, 250);
    press();
    chk("done_exit_valid", result_valid, 0);
    chk("done_exit_result_kept", result, 250);

    // False start 10 cycles into WAIT
    wait_small(3, 150, g);
    press();
    led_seen = 1'b0;
    for (int i = 0; i < 9; i++) begin
      step(1);
      led_seen = led_seen | led;
    end
    press();
    chk("fs_led_never", led_seen | led, 0);
    chk("fs_early", early, 1);
    chk("fs_result", result, 0);
    chk("fs_valid", result_valid, 1);
    press();
    chk("fs_exit_early", early, 0);
    chk("fs_exit_valid", result_valid, 0);

    // Press on the exact expiry tick
    wait_small(1, 150, g);
    d = m_delay(m_lfsr);
    press();
    step(4 * d - 1);
    chk("tie_led_before", led, 0);
    press();
    chk("tie_early", early, 1);
    chk("tie_result", result, 0);
    chk("tie_led", led, 0);
    press();

    // Timeout with no press
    wait_small(1, 150, g);
    d = m_delay(m_lfsr);
    press();
    wait_led(n);
    chk("to_led_rise_cycles", n, 4 * d);
    step(4 * 9999 - 1);
    chk("to_led_last", led, 1);
    chk("to_valid_last", result_valid, 0);
    step(1);
    chk("to_result", result, 9999);
    chk("to_valid", result_valid, 1);
    chk("to_led", led, 0);
    chk("to_early", early, 0);
    press();

    // Reset in the middle of REACT
    wait_small(1, 150, g);
    press();
    wait_led(n);
    chk("mid_led_up", led, 1);
    step(20);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_led", led, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_valid", result_valid, 0);
    chk("mid_rst_early", early, 0);
    chk("mid_rst_result", result, 0);
    chk("mid_rst_lfsr", dut.u_lfsr.q, 12'hACE);
    step(1);
    reset = 1'b0;
    step(g0);
    press();
    chk("mid_repeat_delay", dut.delay_q, d1);
    press();
    press();

    // Delay range sweep
    seen_hi = 1'b0;
    for (int r = 0; r < 2000; r++) begin
      step($urandom_range(0, 7));
      d = m_delay(m_lfsr);
      press();
      chk("sweep_delay", dut.delay_q, d);
      chk("sweep_range", (dut.delay_q >= 12'd1) && (dut.delay_q <= 12'd2999), 1);
      if (dut.delay_q >= 12'd2048) seen_hi = 1'b1;
      press();
      press();
    end
    chk("sweep_seen_hi", seen_hi, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
